// File: rtl/clock_set_ctrl_if.sv
// Front-panel bus of the clock set controller: debounced keys and the second
// tick in, run/adjust strobes, blink masks and mode out.
interface clock_set_ctrl_if;
  logic       sec_tick;
  logic       key_mode;
  logic       key_up;
  logic       key_ten;
  logic       en;
  logic       adjust_hour;
  logic       adjust_minute;
  logic       adjust_minute_10;
  logic       blink_hour;
  logic       blink_min;
  logic [1:0] mode;

  modport master (
    output sec_tick, key_mode, key_up, key_ten,
    input  en, adjust_hour, adjust_minute, adjust_minute_10,
    input  blink_hour, blink_min, mode
  );

  modport slave (
    input  sec_tick, key_mode, key_up, key_ten,
    output en, adjust_hour, adjust_minute, adjust_minute_10,
    output blink_hour, blink_min, mode
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode sequencer for the clock counter chain: turns key levels into run enable,
// single-cycle adjust strobes with auto-repeat, idle timeout and blink masks.
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100,
  parameter int unsigned BLINK_HALF    = 250,
  parameter int unsigned TIMEOUT       = 60000
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  localparam logic [15:0] DELAY_C      = 16'(REPEAT_DELAY);
  localparam logic [15:0] PERIOD_C     = 16'(REPEAT_PERIOD);
  localparam logic [15:0] BLINK_LAST_C = 16'(BLINK_HALF - 1);
  localparam logic [15:0] IDLE_LAST_C  = 16'(TIMEOUT - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_r;
  logic        key_mode_q_r;
  logic        key_up_q_r;
  logic        key_ten_q_r;
  logic        hold_act_r;
  logic        rpt_on_r;
  logic [15:0] hold_r;
  logic [15:0] per_r;
  logic [15:0] idle_r;
  logic [15:0] blink_cnt_r;
  logic        phase_r;
  logic        en_r;
  logic        adj_hour_r;
  logic        adj_min_r;
  logic        adj_min10_r;
  logic        blink_hour_r;
  logic        blink_min_r;

  logic        mode_edge_s;
  logic        up_edge_s;
  logic        ten_edge_s;
  logic        in_set_s;
  logic        timeout_s;
  logic        adj_ok_s;
  logic        delay_hit_s;
  logic        period_hit_s;
  logic        up_pulse_s;
  logic        ten_pulse_s;
  state_t      state_nxt_s;
  logic        hold_act_nxt_s;
  logic        rpt_on_nxt_s;
  logic [15:0] hold_nxt_s;
  logic [15:0] per_nxt_s;
  logic [15:0] idle_nxt_s;
  logic [15:0] blink_cnt_nxt_s;
  logic        phase_nxt_s;

  assign bus.en               = en_r;
  assign bus.adjust_hour      = adj_hour_r;
  assign bus.adjust_minute    = adj_min_r;
  assign bus.adjust_minute_10 = adj_min10_r;
  assign bus.blink_hour       = blink_hour_r;
  assign bus.blink_min        = blink_min_r;
  assign bus.mode             = state_r;

  // Edge detection, mode sequencing and adjust/repeat/timeout/blink next values.
  always_comb begin
    mode_edge_s     = bus.key_mode & ~key_mode_q_r;
    up_edge_s       = bus.key_up & ~key_up_q_r;
    ten_edge_s      = bus.key_ten & ~key_ten_q_r;
    in_set_s        = (state_r == ST_SET_HOUR) || (state_r == ST_SET_MIN);
    timeout_s       = in_set_s && !mode_edge_s && !up_edge_s && !ten_edge_s &&
                      (idle_r >= IDLE_LAST_C);
    state_nxt_s     = ST_RUN;
    hold_act_nxt_s  = 1'b0;
    rpt_on_nxt_s    = 1'b0;
    hold_nxt_s      = 16'd0;
    per_nxt_s       = 16'd0;
    idle_nxt_s      = 16'd0;
    blink_cnt_nxt_s = 16'd0;
    phase_nxt_s     = 1'b0;

    case (state_r)
      ST_RUN: begin
        if (mode_edge_s) state_nxt_s = ST_SET_HOUR;
        else             state_nxt_s = ST_RUN;
      end
      ST_SET_HOUR: begin
        if (mode_edge_s)    state_nxt_s = ST_SET_MIN;
        else if (timeout_s) state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_SET_HOUR;
      end
      ST_SET_MIN: begin
        if (mode_edge_s)    state_nxt_s = ST_RUN;
        else if (timeout_s) state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_SET_MIN;
      end
      default: state_nxt_s = ST_RUN;
    endcase

    // A mode edge or a timeout in this cycle suppresses every adjust.
    adj_ok_s     = in_set_s && !mode_edge_s && !timeout_s;
    delay_hit_s  = hold_act_r && !rpt_on_r && (hold_r == DELAY_C);
    period_hit_s = hold_act_r && rpt_on_r && (per_r == PERIOD_C);
    up_pulse_s   = adj_ok_s && bus.key_up &&
                   (up_edge_s || delay_hit_s || period_hit_s);
    ten_pulse_s  = adj_ok_s && ten_edge_s && (state_r == ST_SET_MIN);

    if (!adj_ok_s || !bus.key_up) begin
      hold_act_nxt_s = 1'b0;
      rpt_on_nxt_s   = 1'b0;
      hold_nxt_s     = 16'd0;
      per_nxt_s      = 16'd0;
    end else if (up_edge_s) begin
      hold_act_nxt_s = 1'b1;
      rpt_on_nxt_s   = 1'b0;
      hold_nxt_s     = 16'd1;
      per_nxt_s      = 16'd0;
    end else if (hold_act_r) begin
      hold_act_nxt_s = 1'b1;
      hold_nxt_s     = sat_inc(hold_r);
      if (delay_hit_s) begin
        rpt_on_nxt_s = 1'b1;
        per_nxt_s    = 16'd1;
      end else if (period_hit_s) begin
        rpt_on_nxt_s = 1'b1;
        per_nxt_s    = 16'd1;
      end else begin
        rpt_on_nxt_s = rpt_on_r;
        per_nxt_s    = rpt_on_r ? sat_inc(per_r) : per_r;
      end
    end else begin
      hold_act_nxt_s = 1'b0;
      rpt_on_nxt_s   = 1'b0;
      hold_nxt_s     = 16'd0;
      per_nxt_s      = 16'd0;
    end

    // Repeat pulses deliberately leave the idle counter running.
    if (!in_set_s || mode_edge_s || up_edge_s || ten_edge_s ||
        (state_nxt_s != state_r)) begin
      idle_nxt_s = 16'd0;
    end else begin
      idle_nxt_s = sat_inc(idle_r);
    end

    if ((state_nxt_s == ST_RUN) || (state_nxt_s != state_r) ||
        up_pulse_s || ten_pulse_s) begin
      blink_cnt_nxt_s = 16'd0;
      phase_nxt_s     = 1'b0;
    end else if (blink_cnt_r >= BLINK_LAST_C) begin
      blink_cnt_nxt_s = 16'd0;
      phase_nxt_s     = ~phase_r;
    end else begin
      blink_cnt_nxt_s = blink_cnt_r + 16'd1;
      phase_nxt_s     = phase_r;
    end
  end

  // Mode FSM, key history, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      key_mode_q_r <= 1'b1;
      key_up_q_r   <= 1'b1;
      key_ten_q_r  <= 1'b1;
      hold_act_r   <= 1'b0;
      rpt_on_r     <= 1'b0;
      hold_r       <= 16'd0;
      per_r        <= 16'd0;
      idle_r       <= 16'd0;
      blink_cnt_r  <= 16'd0;
      phase_r      <= 1'b0;
      en_r         <= 1'b0;
      adj_hour_r   <= 1'b0;
      adj_min_r    <= 1'b0;
      adj_min10_r  <= 1'b0;
      blink_hour_r <= 1'b0;
      blink_min_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      key_mode_q_r <= bus.key_mode;
      key_up_q_r   <= bus.key_up;
      key_ten_q_r  <= bus.key_ten;
      hold_act_r   <= hold_act_nxt_s;
      rpt_on_r     <= rpt_on_nxt_s;
      hold_r       <= hold_nxt_s;
      per_r        <= per_nxt_s;
      idle_r       <= idle_nxt_s;
      blink_cnt_r  <= blink_cnt_nxt_s;
      phase_r      <= phase_nxt_s;
      en_r         <= bus.sec_tick && (state_r == ST_RUN);
      adj_hour_r   <= up_pulse_s && (state_r == ST_SET_HOUR);
      adj_min_r    <= up_pulse_s && (state_r == ST_SET_MIN);
      adj_min10_r  <= ten_pulse_s;
      blink_hour_r <= phase_nxt_s && (state_nxt_s == ST_SET_HOUR);
      blink_min_r  <= phase_nxt_s && (state_nxt_s == ST_SET_MIN);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expected output vectors are queued as each
// step is driven and checked just after the clock edge that samples it.
module tb_clock_set_ctrl;
  localparam int RD = 5;
  localparam int RP = 3;
  localparam int BH = 4;
  localparam int TO = 20;

  localparam logic [7:0] MALL = 8'hFF;
  localparam logic [7:0] MNB  = 8'hCF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .BLINK_HALF   (BH),
    .TIMEOUT      (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Bit order: mode[7:6] blink_min blink_hour adj_min10 adj_min adj_hour en
  logic [7:0] obs;
  assign obs = {bus.mode, bus.blink_min, bus.blink_hour, bus.adjust_minute_10,
                bus.adjust_minute, bus.adjust_hour, bus.en};

  typedef struct {
    string      tag;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic [7:0] blink_bit(input int k, input logic [7:0] b);
    if (((k / BH) % 2) == 1) return b;
    else return 8'h00;
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] val, input logic [7:0] mask);
    exp_t e;
    e.tag  = tag;
    e.val  = val;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    tests_run++;
    assert ((obs & e.mask) === (e.val & e.mask))
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.val & e.mask);
    end
  endtask

  task automatic cyc(input string tag, input logic [7:0] val, input logic [7:0] mask);
    push_exp(tag, val, mask);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic now_chk(input string tag, input logic [7:0] val, input logic [7:0] mask);
    push_exp(tag, val, mask);
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int    lastp;
    logic  pulse;
    string tg;

    bus.sec_tick = 1'b0;
    bus.key_mode = 1'b1;
    bus.key_up   = 1'b0;
    bus.key_ten  = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1 now_chk("reset_outputs", 8'h00, MALL);
    #2 rst_n = 1'b1;

    // Mode key held through reset must not register as an edge.
    for (int i = 0; i < 3; i++) cyc("rst_key_held", 8'h00, MALL);
    bus.key_mode = 1'b0; cyc("rst_key_release", 8'h00, MALL);

    bus.sec_tick = 1'b1; cyc("en_run", 8'h01, MALL);
    bus.sec_tick = 1'b0; cyc("en_off", 8'h00, MALL);

    bus.key_mode = 1'b1; cyc("mode_to_hour", 8'h40, MALL);
    bus.key_mode = 1'b0; bus.sec_tick = 1'b1; cyc("en_frozen_hour", 8'h40, MNB);
    bus.sec_tick = 1'b0; bus.key_ten = 1'b1; cyc("ten_in_hour", 8'h40, MNB);

    bus.key_ten = 1'b0; bus.key_mode = 1'b1; bus.key_up = 1'b1;
    cyc("mode_beats_up", 8'h80, MALL);
    bus.key_mode = 1'b0;
    for (int j = 0; j < 6; j++) cyc("held_up_no_edge", 8'h80, MNB);
    bus.key_up = 1'b0; cyc("up_release", 8'h80, MNB);

    bus.key_up = 1'b1; bus.key_ten = 1'b1; cyc("up_ten_same", 8'h8C, MALL);
    bus.key_up = 1'b0; bus.key_ten = 1'b0;
    for (int j = 1; j <= 5; j++) cyc("blink_min_pre", 8'h80 | blink_bit(j, 8'h20), MALL);
    bus.key_up = 1'b1; cyc("adjust_clears_blink", 8'h84, MALL);
    bus.key_up = 1'b0;
    for (int j = 1; j < TO; j++) cyc("blink_min", 8'h80 | blink_bit(j, 8'h20), MALL);
    cyc("timeout_min", 8'h00, MALL);

    bus.sec_tick = 1'b1; cyc("en_after_timeout", 8'h01, MALL);
    bus.sec_tick = 1'b0; bus.key_up = 1'b1; cyc("up_in_run", 8'h00, MALL);
    bus.key_up = 1'b0; cyc("run_idle", 8'h00, MALL);

    // Hour auto-repeat: key_up held 14 cycles, then released.
    bus.key_mode = 1'b1; cyc("hour_again", 8'h40, MALL);
    bus.key_mode = 1'b0; cyc("hour_idle", 8'h40, MALL);
    lastp = 0;
    for (int j = 0; j < TO; j++) begin
      bus.key_up = (j < 14);
      pulse = (j == 0) || ((j >= RD) && (j < 14) && (((j - RD) % RP) == 0));
      if (pulse) begin
        lastp = j;
        tg = "rpt_pulse";
      end else begin
        tg = "rpt_gap";
      end
      cyc(tg, 8'h40 | (pulse ? 8'h02 : 8'h00) | blink_bit(j - lastp, 8'h10), MALL);
    end
    bus.key_up = 1'b0; cyc("timeout_hour", 8'h00, MALL);

    // Asynchronous reset from a set mode.
    bus.key_mode = 1'b1; cyc("hour_for_reset", 8'h40, MALL);
    bus.key_mode = 1'b0; cyc("hour_before_reset", 8'h40, MNB);
    #3 rst_n = 1'b0;
    #1 now_chk("async_reset", 8'h00, MALL);
    #2 rst_n = 1'b1;
    cyc("after_reset", 8'h00, MALL);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
